// File: rtl/axi64_pkt_rr_arb_if.sv
// Bus bundle for the packet arbiter: NUM_PORTS 64-bit AXI-stream sources on
// the i_* side and one shared 64-bit AXI-stream sink on the o_* side.
//
// Handshake: a beat transfers on a clock edge where tvalid and tready are both
// high. The producer holds tdata/tlast/tuser stable while tvalid is high and
// tready is low. tvalid never depends combinationally on tready.
interface axi64_pkt_rr_arb_if #(
    parameter int NUM_PORTS = 4
) ();
    logic [64*NUM_PORTS-1:0] i_tdata;
    logic [NUM_PORTS-1:0]    i_tlast;
    logic [4*NUM_PORTS-1:0]  i_tuser;
    logic [NUM_PORTS-1:0]    i_tvalid;
    logic [NUM_PORTS-1:0]    i_tready;
    logic [63:0]             o_tdata;
    logic                    o_tlast;
    logic [3:0]              o_tuser;
    logic                    o_tvalid;
    logic                    o_tready;

    // Arbiter side: consumes the sources, drives the shared sink.
    modport slave (
        input  i_tdata, i_tlast, i_tuser, i_tvalid, o_tready,
        output i_tready, o_tdata, o_tlast, o_tuser, o_tvalid
    );

    // Environment side: drives the sources, consumes the shared sink.
    modport master (
        output i_tdata, i_tlast, i_tuser, i_tvalid, o_tready,
        input  i_tready, o_tdata, o_tlast, o_tuser, o_tvalid
    );
endinterface

// File: rtl/axi64_pkt_rr_arb.sv
// Packet-granular arbiter sharing one 64-bit AXI-stream TX path between
// NUM_PORTS sources. One source owns the path from grant until its tlast beat
// is accepted; there is one idle (arbitration) cycle between packets.
// PRIO=0 selects round-robin, PRIO=1 fixed priority with the lowest index winning.
module axi64_pkt_rr_arb #(
    parameter int NUM_PORTS = 4,
    parameter int PRIO      = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [NUM_PORTS-1:0] enable,
    axi64_pkt_rr_arb_if.slave    bus,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 busy,
    output logic                 state_dbg
);
    localparam int IDX_W = $clog2(NUM_PORTS);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_found;
    logic [NUM_PORTS-1:0] req;
    logic                 eop;
    logic [63:0]          tdata_arr [NUM_PORTS];
    logic [3:0]           tuser_arr [NUM_PORTS];

    // Split the flat per-port buses into per-port lanes.
    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_lane
        assign tdata_arr[k] = bus.i_tdata[64*k +: 64];
        assign tuser_arr[k] = bus.i_tuser[4*k +: 4];
    end

    // enable only matters here, so it is effectively sampled only in IDLE.
    assign req = bus.i_tvalid & enable;

    // Winner search: from rr_ptr upward with wrap (round-robin) or from 0 (priority).
    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = (PRIO != 0) ? i : int'(rr_ptr_q) + i;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            if (!win_found && req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Next-state logic and the combinational pass-through from the owner.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        eop           = 1'b0;
        bus.o_tdata   = '0;
        bus.o_tlast   = 1'b0;
        bus.o_tuser   = '0;
        bus.o_tvalid  = 1'b0;
        bus.i_tready  = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d          = BUSY;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    owner_d          = win_idx;
                end
            end
            BUSY: begin
                bus.o_tdata           = tdata_arr[owner_q];
                bus.o_tuser           = tuser_arr[owner_q];
                bus.o_tlast           = bus.i_tlast[owner_q];
                bus.o_tvalid          = bus.i_tvalid[owner_q];
                bus.i_tready[owner_q] = bus.o_tready;
                eop = bus.i_tvalid[owner_q] & bus.o_tready & bus.i_tlast[owner_q];
                if (eop) begin
                    state_d = IDLE;
                    grant_d = '0;
                    if (PRIO == 0) begin
                        rr_ptr_d = (owner_q == IDX_W'(NUM_PORTS - 1)) ? '0
                                                                      : owner_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; clear behaves exactly like reset and drops any grant at once.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = (state_q == BUSY);
    assign state_dbg = state_q;
endmodule

// File: tb/tb_axi64_pkt_rr_arb.sv
// Bench for axi64_pkt_rr_arb: a round-robin instance driven by queued packet
// sources and checked cycle by cycle against a packet-level reference model,
// plus a fixed-priority instance exercised directly.
module tb_axi64_pkt_rr_arb;
    localparam int NP = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          clear_a, clear_b;
    logic [NP-1:0] enable_a, enable_b, grant_a, grant_b;
    logic          busy_a, busy_b, st_a, st_b;

    axi64_pkt_rr_arb_if #(.NUM_PORTS(NP)) ifa ();
    axi64_pkt_rr_arb_if #(.NUM_PORTS(NP)) ifb ();

    axi64_pkt_rr_arb #(.NUM_PORTS(NP), .PRIO(0)) dut_rr (
        .clk(clk), .reset(reset), .clear(clear_a), .enable(enable_a),
        .bus(ifa), .grant(grant_a), .busy(busy_a), .state_dbg(st_a)
    );

    axi64_pkt_rr_arb #(.NUM_PORTS(NP), .PRIO(1)) dut_pr (
        .clk(clk), .reset(reset), .clear(clear_b), .enable(enable_b),
        .bus(ifb), .grant(grant_b), .busy(busy_b), .state_dbg(st_b)
    );

    // ---------------- reference model state ----------------
    logic [68:0]   src_q [NP][$];   // pending beats per source: {last, user, data}
    logic [NP-1:0] pend;            // valid shown but not yet accepted (must hold)
    int            owner_m;         // -1 when idle
    int            ptr_m;
    bit            rand_valid, rand_rdy;
    bit            rdy_pat[$];
    int            pkt_id;

    // ---------------- scoreboard / bookkeeping ----------------
    int            errors, checks;
    int            cyc, beats_out;
    logic [NP-1:0] gnt_log[$];
    int            gnt_cyc[$];
    logic          prev_busy;
    logic [3:0]    last_user_obs;
    logic [NP-1:0] obs_grant;
    logic          obs_busy, obs_tvalid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input int p, input int n, input logic [3:0] user);
        logic [63:0] d;
        for (int b = 0; b < n; b++) begin
            d = {8'(p), 8'(b), 16'(pkt_id), 32'($urandom())};
            src_q[p].push_back({(b == n - 1), ((b == n - 1) ? user : 4'h0), d});
        end
        pkt_id++;
    endtask

    function automatic int pick_rr(input logic [NP-1:0] req, input int ptr);
        int p;
        for (int k = 0; k < NP; k++) begin
            p = (ptr + k) % NP;
            if (req[p]) return p;
        end
        return -1;
    endfunction

    // ---------------- driver ----------------
    task automatic drive();
        logic [68:0] head;
        logic        v;
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() > 0) begin
                head = src_q[p][0];
                v = pend[p] || !rand_valid || ($urandom_range(0, 3) != 0);
            end else begin
                head = '0;
                v = 1'b0;
            end
            ifa.i_tvalid[p]          = v;
            ifa.i_tdata[64*p +: 64]  = head[63:0];
            ifa.i_tuser[4*p +: 4]    = head[67:64];
            ifa.i_tlast[p]           = head[68];
        end
        if (rdy_pat.size() > 0) ifa.o_tready = rdy_pat.pop_front();
        else if (rand_rdy)      ifa.o_tready = ($urandom_range(0, 2) != 0);
        else                    ifa.o_tready = 1'b1;
    endtask

    // One clock: drive, check outputs against the model at negedge, advance model.
    task automatic cycle();
        int            acc;
        logic [NP-1:0] eg;
        logic [68:0]   head;
        drive();
        @(negedge clk);
        obs_grant  = grant_a;
        obs_busy   = busy_a;
        obs_tvalid = ifa.o_tvalid;
        if (busy_a && !prev_busy) begin
            gnt_log.push_back(grant_a);
            gnt_cyc.push_back(cyc);
        end
        prev_busy = busy_a;
        if (ifa.o_tvalid && ifa.o_tready) begin
            beats_out++;
            if (ifa.o_tlast) last_user_obs = ifa.o_tuser;
        end
        acc = -1;
        if (owner_m < 0) begin
            chk("idle_grant", grant_a, '0);
            chk("idle_busy", busy_a, 1'b0);
            chk("idle_state", st_a, 1'b0);
            chk("idle_o_tvalid", ifa.o_tvalid, 1'b0);
            chk("idle_i_tready", ifa.i_tready, '0);
        end else begin
            eg = NP'(1) << owner_m;
            chk("busy_grant", grant_a, eg);
            chk("busy_busy", busy_a, 1'b1);
            chk("busy_state", st_a, 1'b1);
            chk("busy_o_tvalid", ifa.o_tvalid, ifa.i_tvalid[owner_m]);
            chk("busy_i_tready", ifa.i_tready, ifa.o_tready ? eg : '0);
            if (ifa.i_tvalid[owner_m]) begin
                head = src_q[owner_m][0];
                chk("o_tdata", ifa.o_tdata, head[63:0]);
                chk("o_tuser", ifa.o_tuser, head[67:64]);
                chk("o_tlast", ifa.o_tlast, head[68]);
                if (ifa.o_tready) acc = owner_m;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (owner_m < 0) begin
            owner_m = pick_rr(ifa.i_tvalid & enable_a, ptr_m);
        end else if (acc >= 0) begin
            head = src_q[acc].pop_front();
            if (head[68]) begin
                ptr_m   = (owner_m + 1) % NP;
                owner_m = -1;
            end
        end
        for (int p = 0; p < NP; p++) pend[p] = ifa.i_tvalid[p] && (acc != p);
        if (clear_a) begin
            owner_m = -1;
            ptr_m   = 0;
            for (int p = 0; p < NP; p++) src_q[p].delete();
            pend    = '0;
            clear_a = 1'b0;
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin : main
        int          b0, c0, n2;
        logic [NP-1:0] exp_g [5];
        errors = 0; checks = 0; cyc = 0; beats_out = 0; pkt_id = 0;
        owner_m = -1; ptr_m = 0; pend = '0; prev_busy = 1'b0;
        rand_valid = 1'b0; rand_rdy = 1'b0; last_user_obs = '0;
        reset = 1'b1; clear_a = 1'b0; clear_b = 1'b0;
        enable_a = '1; enable_b = '1;
        ifa.i_tdata = '0; ifa.i_tlast = '0; ifa.i_tuser = '0; ifa.i_tvalid = '0; ifa.o_tready = 1'b0;
        ifb.i_tdata = '0; ifb.i_tlast = '0; ifb.i_tuser = '0; ifb.i_tvalid = '0; ifb.o_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_grant", grant_a, '0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_o_tvalid", ifa.o_tvalid, 1'b0);
        chk("rst_i_tready", ifa.i_tready, '0);
        chk("rst_prio_grant", grant_b, '0);
        @(posedge clk);
        #1;

        // Single 3-beat packet on port 1, tuser=5 on the last beat.
        add_pkt(1, 3, 4'd5);
        gnt_log.delete(); gnt_cyc.delete(); b0 = beats_out; c0 = cyc;
        repeat (6) cycle();
        chk("t1_npkts", gnt_log.size(), 1);
        chk("t1_grant", gnt_log[0], 4'b0010);
        chk("t1_grant_latency", gnt_cyc[0] - c0, 1);
        chk("t1_beats", beats_out - b0, 3);
        chk("t1_last_tuser", last_user_obs, 4'd5);
        chk("t1_grant_after", grant_a, '0);

        // Clear while idle, then all four ports with 2-beat packets (port 0 twice).
        clear_a = 1'b1;
        cycle();
        for (int p = 0; p < NP; p++) add_pkt(p, 2, 4'($urandom_range(0, 15)));
        add_pkt(0, 2, 4'd3);
        gnt_log.delete(); gnt_cyc.delete(); b0 = beats_out;
        repeat (17) cycle();
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        chk("t2_npkts", gnt_log.size(), 5);
        for (int i = 0; i < 5 && i < gnt_log.size(); i++) chk("t2_order", gnt_log[i], exp_g[i]);
        for (int i = 1; i < gnt_cyc.size(); i++) chk("t2_gap", gnt_cyc[i] - gnt_cyc[i-1], 3);
        chk("t2_beats", beats_out - b0, 10);

        // enable=1011 with ports 2,3 requesting; drop enable[3] mid-packet.
        enable_a = 4'b1011;
        add_pkt(2, 4, 4'd1);
        add_pkt(3, 4, 4'd7);
        gnt_log.delete(); b0 = beats_out;
        repeat (3) cycle();
        enable_a = 4'b0011;
        repeat (6) cycle();
        chk("t3_npkts", gnt_log.size(), 1);
        chk("t3_grant", gnt_log[0], 4'b1000);
        chk("t3_beats", beats_out - b0, 4);
        chk("t3_disabled_idle", grant_a, '0);
        enable_a = '1;
        repeat (6) cycle();
        chk("t3_beats_all", beats_out - b0, 8);

        // o_tready 1,0,0,1 during a 4-beat packet while port 1 waits.
        add_pkt(0, 4, 4'd2);
        add_pkt(1, 2, 4'd6);
        rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        gnt_log.delete(); b0 = beats_out;
        repeat (12) cycle();
        chk("t4_npkts", gnt_log.size(), 2);
        chk("t4_first", gnt_log[0], 4'b0001);
        chk("t4_second", gnt_log[1], 4'b0010);
        chk("t4_beats", beats_out - b0, 6);

        // Clear on beat 2 of a 4-beat packet, then re-arbitrate from pointer 0.
        clear_a = 1'b1;
        cycle();
        add_pkt(2, 4, 4'd4);
        cycle();
        cycle();
        clear_a = 1'b1;
        cycle();
        cycle();
        chk("t5_grant", obs_grant, '0);
        chk("t5_busy", obs_busy, 1'b0);
        chk("t5_o_tvalid", obs_tvalid, 1'b0);
        add_pkt(1, 1, 4'd1);
        add_pkt(3, 1, 4'd2);
        gnt_log.delete();
        repeat (6) cycle();
        chk("t5_npkts", gnt_log.size(), 2);
        chk("t5_first", gnt_log[0], 4'b0010);
        chk("t5_second", gnt_log[1], 4'b1000);

        // Randomized traffic: valid gaps, backpressure, enable changes, rare clears.
        rand_valid = 1'b1;
        rand_rdy   = 1'b1;
        for (int t = 0; t < 800; t++) begin
            for (int p = 0; p < NP; p++) begin
                if (src_q[p].size() < 6 && $urandom_range(0, 7) == 0)
                    add_pkt(p, $urandom_range(1, 4), 4'($urandom_range(0, 15)));
            end
            if (t % 50 == 49) enable_a = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'hF;
            if ($urandom_range(0, 199) == 0) clear_a = 1'b1;
            cycle();
        end
        enable_a = '1;
        repeat (100) cycle();

        // Park the round-robin instance idle.
        clear_a = 1'b1;
        cycle();

        // Fixed priority: ports 2 and 3 both request single-beat packets.
        ifb.i_tdata  = {64'hDDDD_0000_0000_0003, 64'hDDDD_0000_0000_0002, 64'h0, 64'h0};
        ifb.i_tlast  = '1;
        ifb.i_tuser  = '0;
        ifb.i_tvalid = 4'b1100;
        n2 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("prio_never_p3", (grant_b === 4'b0100 || grant_b === 4'b0000), 1'b1);
            if (grant_b === 4'b0100) n2++;
        end
        chk("prio_p2_count", n2, 4);
        @(posedge clk);
        #1 ifb.i_tvalid = 4'b1000;
        @(negedge clk);
        chk("prio_idle", grant_b, '0);
        @(negedge clk);
        chk("prio_p3_grant", grant_b, 4'b1000);
        chk("prio_p3_valid", ifb.o_tvalid, 1'b1);
        chk("prio_p3_data", ifb.o_tdata, 64'hDDDD_0000_0000_0003);
        chk("prio_p3_ready", ifb.i_tready, 4'b1000);
        @(posedge clk);
        #1 ifb.i_tvalid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
